// File: rtl/cpu_axi_pkg.sv
// -----------------------------------------------------------------------------
// cpu_axi_pkg
// Shared AXI constants and types for the CPU-side AXI3 SRAM slave:
//   - channel widths (4-bit IDs, 32-bit address/data, 8-bit len)
//   - response codes, burst encodings, slave FSM state enum
//   - clamp_len(): limits a requested burst length to the supported maximum
// -----------------------------------------------------------------------------
package cpu_axi_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WRESP
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_if
// AXI3 bus bundle between the CPU master and the SRAM slave: AR, R, AW, W, B.
//   master modport: drives AR/AW/W payloads+valids, rready, bready
//   slave  modport: drives arready/awready/wready, R and B payloads+valids
// arlock/arcache/arprot and their AW twins are carried but not interpreted.
// -----------------------------------------------------------------------------
interface axi_sram_slave_if;
    import cpu_axi_pkg::*;

    // AR channel
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    // R channel
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // AW channel
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    // W channel
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    // B channel
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_addr_gen
// Combinational next-beat byte address for a burst.
//   addr      in  32  current beat address
//   size      in  3   AXI size; sizes above 4 bytes step by one word
//   burst     in  2   FIXED holds the address; INCR/WRAP (and reserved) increment
//   next_addr out 32  address of the following beat, wraps modulo 2^32
// -----------------------------------------------------------------------------
module axi_addr_gen
    import cpu_axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;

    always_comb begin
        step      = (size > 3'd2) ? ADDR_W'(4) : (ADDR_W'(1) << size);
        // WRAP is deliberately treated as INCR; no wrap boundary is computed.
        next_addr = (burst == BURST_FIXED) ? addr : addr + step;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI3 slave serving one read or write burst at a time from a synchronous
// single-port SRAM (one-cycle read latency, read data held until next access).
//   aclk, areset  clock and asynchronous active-high reset
//   axi           slave side of the AXI bus (AR/R/AW/W/B)
//   sram_en       SRAM access strobe
//   sram_we       byte write enables, 0 = read
//   sram_addr     SRAM word address (AXI byte address bits [ADDR_WIDTH+1:2])
//   sram_wdata    write data
//   sram_rdata    read data, valid the cycle after a read strobe
// Simultaneous AR/AW requests are granted round-robin, reads first after reset.
// Lengths above MAX_LEN are clamped and answered with SLVERR.
// -----------------------------------------------------------------------------
module axi_sram_slave
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_LEN    = 15
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_sram_slave_if.slave       axi,
    output logic                  sram_en,
    output logic [STRB_W-1:0]     sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e            state_q,   state_d;
    logic [ID_W-1:0]   id_q,      id_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic [LEN_W-1:0]  cnt_q,     cnt_d;      // beats issued (RD) or written (WR)
    logic [2:0]        size_q,    size_d;
    logic [1:0]        burst_q,   burst_d;
    logic              err_q,     err_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic              bvalid_q,  bvalid_d;
    logic              prio_rd_q, prio_rd_d;  // 1: read wins the next AR/AW tie

    logic [ADDR_W-1:0] next_addr;
    logic              grant_rd, grant_wr;

    axi_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // NOTE: every output of this block gets a default first, so no path can leave a
    // signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        burst_d     = burst_q;
        err_d       = err_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        bvalid_d    = bvalid_q;
        prio_rd_d   = prio_rd_q;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        sram_en     = 1'b0;
        sram_we     = '0;

        unique case (state_q)
            ST_IDLE: begin
                grant_rd    = axi.arvalid && (prio_rd_q || !axi.awvalid);
                grant_wr    = axi.awvalid && !grant_rd;
                axi.arready = grant_rd;
                axi.awready = grant_wr;
                cnt_d       = '0;
                rlast_d     = 1'b0;
                if (grant_rd) begin
                    id_d      = axi.arid;
                    addr_d    = axi.araddr;
                    len_d     = clamp_len(axi.arlen, MAX_LEN_L);
                    size_d    = axi.arsize;
                    burst_d   = axi.arburst;
                    err_d     = (axi.arlen > MAX_LEN_L) || (axi.arsize > 3'd2);
                    prio_rd_d = 1'b0;
                    state_d   = ST_RD;
                end else if (grant_wr) begin
                    id_d      = axi.awid;
                    addr_d    = axi.awaddr;
                    len_d     = clamp_len(axi.awlen, MAX_LEN_L);
                    size_d    = axi.awsize;
                    burst_d   = axi.awburst;
                    err_d     = (axi.awlen > MAX_LEN_L) || (axi.awsize > 3'd2);
                    prio_rd_d = 1'b1;
                    state_d   = ST_WR;
                end
            end

            ST_RD: begin
                // Only read when the R slot is empty or draining, so the SRAM output
                // (and hence rdata) stays put while the master stalls.
                sram_en = (cnt_q <= len_q) && (!rvalid_q || axi.rready);
                if (rvalid_q && axi.rready) begin
                    rvalid_d = 1'b0;
                end
                if (sram_en) begin
                    rvalid_d = 1'b1;
                    rlast_d  = (cnt_q == len_q);
                    cnt_d    = cnt_q + 8'd1;
                    addr_d   = next_addr;
                end
                if (rvalid_q && axi.rready && rlast_q) begin
                    rlast_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    // Beats beyond len+1 are absorbed without touching the SRAM.
                    if (cnt_q <= len_q) begin
                        sram_en = 1'b1;
                        sram_we = axi.wstrb;
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                    end
                    if (axi.wlast != (cnt_q == len_q)) begin
                        err_d = 1'b1;
                    end
                    if (axi.wlast) begin
                        bvalid_d = 1'b1;
                        state_d  = ST_WRESP;
                    end
                end
            end

            ST_WRESP: begin
                if (axi.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, matching real hardware.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            prio_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            bvalid_q  <= bvalid_d;
            prio_rd_q <= prio_rd_d;
        end
    end

    assign axi.rvalid = rvalid_q;
    assign axi.rlast  = rlast_q;
    assign axi.rid    = id_q;
    assign axi.rdata  = sram_rdata;
    assign axi.rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi.bvalid = bvalid_q;
    assign axi.bid    = id_q;
    assign axi.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;

    assign sram_addr  = addr_q[ADDR_WIDTH+1:2];
    assign sram_wdata = axi.wdata;

    // Attributes and wid are accepted but intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{axi.arlock, axi.arcache, axi.arprot,
                             axi.awlock, axi.awcache, axi.awprot, axi.wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave with a behavioural SRAM. Memory is preloaded
// with 0xA500_0000 | word_index so expected read data is known by construction.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;
    import cpu_axi_pkg::*;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          aclk;
    logic          areset;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic [31:0]   mem [DEPTH];
    logic          mem_init;

    int n_vec = 0;
    int n_err = 0;

    axi_sram_slave_if axi ();

    axi_sram_slave #(.ADDR_WIDTH(AW), .MAX_LEN(15)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .axi        (axi),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge aclk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (sram_en) begin
            if (sram_we == 4'b0) sram_rdata <= mem[sram_addr];
            else                 mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_we);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1;
        n = 0;
        #1;
        while (!axi.arready && n < 20) begin @(negedge aclk); #1; n++; end
        check("ar_ready", 32'(axi.arready), 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
        axi.awburst = BURST_INCR; axi.awvalid = 1'b1;
        n = 0;
        #1;
        while (!axi.awready && n < 20) begin @(negedge aclk); #1; n++; end
        check("aw_ready", 32'(axi.awready), 32'd1);
        @(negedge aclk);
        axi.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        n = 0;
        #1;
        while (!axi.wready && n < 20) begin @(negedge aclk); #1; n++; end
        check("w_ready", 32'(axi.wready), 32'd1);
        @(negedge aclk);
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic b_wait(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n;
        n = 0;
        while (!axi.bvalid && n < 20) begin @(negedge aclk); n++; end
        check({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
        check({tag, "_bid"},    32'(axi.bid),    32'(id));
        check({tag, "_bresp"},  32'(axi.bresp),  32'(resp));
        @(negedge aclk);
    endtask

    // Collects nbeats R beats with rready held high; word index advances by step.
    task automatic rd_collect(input string tag, input int nbeats, input int first_word,
                              input int step, input logic [1:0] resp, input logic [3:0] id);
        int beat;
        beat = 0;
        for (int c = 0; c < 100 && beat < nbeats; c++) begin
            @(negedge aclk);
            if (axi.rvalid) begin
                check({tag, "_data"}, axi.rdata, 32'hA500_0000 | 32'(first_word + beat * step));
                check({tag, "_rlast"}, 32'(axi.rlast), 32'(beat == nbeats - 1));
                check({tag, "_rresp"}, 32'(axi.rresp), 32'(resp));
                check({tag, "_rid"}, 32'(axi.rid), 32'(id));
                beat++;
            end
        end
        check({tag, "_beats"}, 32'(beat), 32'(nbeats));
        @(negedge aclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        logic [31:0] held;
        logic stalled;

        areset = 1'b1; mem_init = 1'b1;
        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0;
        axi.arburst = 0; axi.arlock = 0; axi.arcache = 0; axi.arprot = 0;
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
        axi.awburst = 0; axi.awlock = 0; axi.awcache = 0; axi.awprot = 0;
        axi.wvalid = 0; axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
        axi.rready = 1'b1; axi.bready = 1'b1;
        repeat (3) @(negedge aclk);

        // Reset state
        check("rst_arready", 32'(axi.arready), 0);
        check("rst_awready", 32'(axi.awready), 0);
        check("rst_wready",  32'(axi.wready),  0);
        check("rst_rvalid",  32'(axi.rvalid),  0);
        check("rst_bvalid",  32'(axi.bvalid),  0);
        check("rst_rlast",   32'(axi.rlast),   0);
        check("rst_ids",     32'({axi.rid, axi.bid}), 0);
        check("rst_resp",    32'({axi.rresp, axi.bresp}), 0);
        check("rst_sram",    32'({sram_en, sram_we}), 0);
        mem_init = 1'b0; areset = 1'b0;
        @(negedge aclk);

        // Arbitration: first tie after reset goes to read
        axi.arid = 4'd1; axi.araddr = 32'h0; axi.arlen = 0; axi.arsize = 3'd2;
        axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
        axi.awid = 4'd2; axi.awaddr = 32'h20; axi.awlen = 0; axi.awsize = 3'd2;
        axi.awburst = BURST_INCR; axi.awvalid = 1'b1;
        #1;
        check("arb1_arready", 32'(axi.arready), 1);
        check("arb1_awready", 32'(axi.awready), 0);
        @(negedge aclk);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        rd_collect("arb1_rd", 1, 0, 1, RESP_OKAY, 4'd1);
        @(negedge aclk);
        // Second tie: last grant was a read, so write wins
        axi.araddr = 32'h4; axi.arvalid = 1'b1;
        axi.awaddr = 32'h24; axi.awvalid = 1'b1;
        #1;
        check("arb2_arready", 32'(axi.arready), 0);
        check("arb2_awready", 32'(axi.awready), 1);
        @(negedge aclk);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        b_wait("arb2_wr", 4'd2, RESP_OKAY);
        check("arb2_mem", mem[9], 32'h1234_5678);

        // Single read: rvalid two cycles after the AR handshake
        do_ar(4'd3, 32'h100, 8'd0, 3'd2, BURST_INCR);
        check("rd1_rvalid_early", 32'(axi.rvalid), 0);
        @(negedge aclk);
        check("rd1_rvalid", 32'(axi.rvalid), 1);
        check("rd1_rdata",  axi.rdata, 32'hA500_0040);
        check("rd1_rlast",  32'(axi.rlast), 1);
        check("rd1_rid",    32'(axi.rid), 3);
        check("rd1_rresp",  32'(axi.rresp), 32'(RESP_OKAY));
        @(negedge aclk);
        check("rd1_rvalid_done", 32'(axi.rvalid), 0);

        // INCR len=3 with rready toggling; data must hold while stalled
        do_ar(4'd4, 32'h200, 8'd3, 3'd2, BURST_INCR);
        beat = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            @(negedge aclk);
            axi.rready = (c % 2 == 0);
            #1;
            if (stalled) check("rd4_stall_hold", axi.rdata, held);
            stalled = 1'b0;
            if (axi.rvalid) begin
                if (axi.rready) begin
                    check("rd4_data", axi.rdata, 32'hA500_0080 | 32'(beat));
                    check("rd4_rlast", 32'(axi.rlast), 32'(beat == 3));
                    beat++;
                end else begin
                    held = axi.rdata;
                    stalled = 1'b1;
                end
            end
        end
        check("rd4_beats", 32'(beat), 4);
        @(negedge aclk);
        axi.rready = 1'b1;

        // Write len=1 with partial strobe on the second beat
        do_aw(4'd7, 32'h10, 8'd1);
        w_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
        w_beat(32'hCAFE_1234, 4'h3, 1'b1);
        b_wait("wr2", 4'd7, RESP_OKAY);
        check("wr2_mem4", mem[4], 32'hDEAD_BEEF);
        check("wr2_mem5", mem[5], 32'hA500_1234);

        // Write len=2 with early wlast: two beats written, SLVERR
        do_aw(4'd8, 32'h40, 8'd2);
        w_beat(32'h1111_1111, 4'hF, 1'b0);
        w_beat(32'h2222_2222, 4'hF, 1'b1);
        b_wait("wr_early", 4'd8, RESP_SLVERR);
        check("wr_early_m10", mem[16], 32'h1111_1111);
        check("wr_early_m11", mem[17], 32'h2222_2222);
        check("wr_early_m12", mem[18], 32'hA500_0012);

        // Write len=1 with late wlast: third beat dropped, SLVERR
        do_aw(4'd9, 32'h80, 8'd1);
        w_beat(32'hAAAA_0001, 4'hF, 1'b0);
        w_beat(32'hAAAA_0002, 4'hF, 1'b0);
        w_beat(32'hAAAA_0003, 4'hF, 1'b1);
        b_wait("wr_late", 4'd9, RESP_SLVERR);
        check("wr_late_m20", mem[32], 32'hAAAA_0001);
        check("wr_late_m21", mem[33], 32'hAAAA_0002);
        check("wr_late_m22", mem[34], 32'hA500_0022);

        // arsize=3: SLVERR on every beat, word step
        do_ar(4'd4, 32'h300, 8'd1, 3'd3, BURST_INCR);
        rd_collect("rd_size3", 2, 32'hC0, 1, RESP_SLVERR, 4'd4);

        // FIXED burst re-reads one word
        do_ar(4'd5, 32'h500, 8'd2, 3'd2, BURST_FIXED);
        rd_collect("rd_fixed", 3, 32'h140, 0, RESP_OKAY, 4'd5);

        // arlen=16 clamps to 16 beats, SLVERR
        do_ar(4'd2, 32'h400, 8'd16, 3'd2, BURST_INCR);
        rd_collect("rd_clamp", 16, 32'h100, 1, RESP_SLVERR, 4'd2);

        // Reset during beat 2 of a 4-beat read, then a fresh read
        do_ar(4'd5, 32'h200, 8'd3, 3'd2, BURST_INCR);
        beat = 0;
        for (int c = 0; c < 20 && beat < 2; c++) begin
            @(negedge aclk);
            if (axi.rvalid) beat++;
        end
        check("rst_mid_beats", 32'(beat), 2);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1 check("rst_mid_async_rvalid", 32'(axi.rvalid), 0);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("rst_mid_rvalid", 32'(axi.rvalid), 0);
        check("rst_mid_bvalid", 32'(axi.bvalid), 0);
        check("rst_mid_wready", 32'(axi.wready), 0);
        check("rst_mid_rlast",  32'(axi.rlast),  0);
        do_ar(4'd6, 32'h104, 8'd0, 3'd2, BURST_INCR);
        rd_collect("post_rst", 1, 32'h41, 1, RESP_OKAY, 4'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
